// File: rtl/stoch_arith_engine.sv
// Stochastic arithmetic core: binary operands -> unipolar LFSR bitstreams -> MUL/SADD/ABSSUB/PASS -> ones count.
// Define STOCH_STREAM_TAP_EN to add the registered bit_out/bit_vld stream tap ports.
module stoch_arith_engine #(
    parameter int WIDTH  = 8,
    parameter int SEED_A = 1,
    parameter int SEED_S = 'h5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef STOCH_STREAM_TAP_EN
    ,
    output logic             bit_out,
    output logic             bit_vld
`endif
);

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_SADD   = 2'b01;
    localparam logic [1:0] MODE_ABSSUB = 2'b10;

    // Maximal-length Fibonacci taps; tap n of the classic tables maps to bit n-1.
    function automatic logic [15:0] tap_table(input int w);
        case (w)
            4:       tap_table = 16'h000C;
            5:       tap_table = 16'h0014;
            6:       tap_table = 16'h0030;
            7:       tap_table = 16'h0060;
            8:       tap_table = 16'h00B8;
            9:       tap_table = 16'h0110;
            10:      tap_table = 16'h0240;
            11:      tap_table = 16'h0500;
            12:      tap_table = 16'h0829;
            13:      tap_table = 16'h100D;
            14:      tap_table = 16'h2015;
            15:      tap_table = 16'h6000;
            default: tap_table = 16'hD008;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16   = tap_table(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS16[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
    localparam logic [WIDTH-1:0] SEED_S_M = WIDTH'(SEED_S);
    localparam logic [WIDTH-1:0] SEED_S_W = (SEED_S_M == '0) ? WIDTH'(1) : SEED_S_M;
    localparam logic [WIDTH-1:0] LAST_CYC = {{(WIDTH-1){1'b1}}, 1'b0};

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        bit_rev = '0;
        for (int i = 0; i < WIDTH; i++) bit_rev[i] = v[WIDTH-1-i];
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        lfsr_step = {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr_a, lfsr_s, ones_cnt, cyc_cnt;
    logic [WIDTH-1:0] op_a_p0, op_b_p0;
    logic [1:0]       mode_p0;
    logic             a_bit, b_bit, b_cor, out_bit;

    // Operand latch: data only, captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (ena && state == S_IDLE && start) begin
            op_a_p0 <= op_a;
            op_b_p0 <= op_b;
            mode_p0 <= mode;
        end
    end

    // Stream generation: every bit is a pure function of the current LFSR state.
    always_comb begin
        a_bit = (lfsr_a <= op_a_p0);
        b_bit = (bit_rev(lfsr_a) <= op_b_p0);
        b_cor = (lfsr_a <= op_b_p0);
        case (mode_p0)
            MODE_MUL:    out_bit = a_bit & b_bit;
            MODE_SADD:   out_bit = lfsr_s[0] ? b_bit : a_bit;
            MODE_ABSSUB: out_bit = a_bit ^ b_cor;
            default:     out_bit = a_bit;
        endcase
    end

    // Control and accumulation stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ones_cnt <= '0;
            cyc_cnt  <= '0;
            lfsr_a   <= SEED_A_W;
            lfsr_s   <= SEED_S_W;
        end else if (ena) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        ones_cnt <= '0;
                        cyc_cnt  <= '0;
                        lfsr_a   <= SEED_A_W;
                        lfsr_s   <= SEED_S_W;
                    end
                end
                S_RUN: begin
                    ones_cnt <= ones_cnt + WIDTH'(out_bit);
                    cyc_cnt  <= cyc_cnt + 1'b1;
                    lfsr_a   <= lfsr_step(lfsr_a);
                    lfsr_s   <= lfsr_step(lfsr_s);
                    if (cyc_cnt == LAST_CYC) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        result <= ones_cnt + WIDTH'(out_bit);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOCH_STREAM_TAP_EN
    // Tap stage: one-cycle registered copy of the live stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_out <= 1'b0;
            bit_vld <= 1'b0;
        end else if (ena) begin
            bit_vld <= (state == S_RUN);
            bit_out <= (state == S_RUN) & out_bit;
        end
    end
`endif

endmodule

// File: tb/tb_stoch_arith_engine.sv
// Scoreboard bench for stoch_arith_engine at WIDTH 4, 8 and 12 running in parallel.
// Expected counts come from set-counting over all nonzero WIDTH-bit values.
module tb_stoch_arith_engine;

    typedef struct {
        int exp;
        int tol;
        int due;
    } item_t;

    bit clk = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W    = 4 + 4 * g;
        localparam int MAXV = (1 << W) - 1;
        localparam bit FULL = (W != 12);

        logic         rst_n, ena, start;
        logic [1:0]   mode;
        logic [W-1:0] op_a, op_b;
        logic         busy, done;
        logic [W-1:0] result;
`ifdef STOCH_STREAM_TAP_EN
        logic         bit_out, bit_vld;
        int           vld_n = 0;
        int           ones_n = 0;
        bit           ena_q = 1'b0;
        bit           rst_q = 1'b0;
`endif
        item_t        sb[$];
        bit           fin = 1'b0;
        bit           armed = 1'b0;
        int           busy_due = -1;

        stoch_arith_engine #(.WIDTH(W), .SEED_A(1), .SEED_S('h5A)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .start  (start),
            .mode   (mode),
            .op_a   (op_a),
            .op_b   (op_b),
            .busy   (busy),
            .done   (done),
            .result (result)
`ifdef STOCH_STREAM_TAP_EN
            ,
            .bit_out(bit_out),
            .bit_vld(bit_vld)
`endif
        );

        function automatic int rev_w(input int x);
            int r = 0;
            for (int i = 0; i < W; i++) if (x[i]) r |= (1 << (W - 1 - i));
            return r;
        endfunction

        // Counts over the full set of stream positions; order does not matter for MUL/ABSSUB/PASS.
        function automatic int model(input int m, input int a, input int b, output int tol);
            int cnt = 0;
            tol = 0;
            case (m)
                0: begin
                    for (int x = 1; x <= MAXV; x++) if (x <= a && rev_w(x) <= b) cnt++;
                    return cnt;
                end
                1: begin
                    tol = 3 << (W / 2 - 1);
                    return (a + b) / 2;
                end
                2: return (a > b) ? a - b : b - a;
                default: return a;
            endcase
        endfunction

        task automatic wait_idle();
            int n = 0;
            while ((sb.size() != 0 || busy) && n < (2 << W) + 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w%0d_run_finished", W), int'(sb.size() != 0 || busy), 0, 0);
        endtask

        task automatic run_op(input int m, input int a, input int b, input int fz, input bit poke);
            int e, t;
            e = model(m, a & MAXV, b & MAXV, t);
            @(negedge clk);
            mode  = 2'(m);
            op_a  = W'(a);
            op_b  = W'(b);
            start = 1'b1;
            sb.push_back('{exp: e, tol: t, due: cyc + (1 << W) + fz});
            @(negedge clk);
            start = 1'b0;
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            mode  = 2'($urandom);
            if (poke) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                op_a  = W'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            if (fz > 0) begin
                repeat (MAXV / 3) @(negedge clk);
                ena = 1'b0;
                repeat (fz) @(negedge clk);
                ena = 1'b1;
            end
            wait_idle();
        endtask

        // Monitor: pops the scoreboard whenever the DUT raises done.
        always @(negedge clk) begin
            item_t it;
`ifdef STOCH_STREAM_TAP_EN
            if (!rst_q) begin
                vld_n  = 0;
                ones_n = 0;
            end else if (ena_q && bit_vld) begin
                vld_n++;
                ones_n += int'(bit_out);
            end
`endif
            if (armed) begin
                if (busy_due == cyc) check($sformatf("w%0d_busy_after_done", W), int'(busy), 0, 0);
                if (done) begin
                    if (sb.size() == 0) begin
                        check($sformatf("w%0d_unexpected_done", W), int'(done), 0, 0);
                    end else begin
                        it = sb.pop_front();
                        check($sformatf("w%0d_result", W), int'(result), it.exp, it.tol);
                        check($sformatf("w%0d_done_cycle", W), cyc, it.due, 0);
                        busy_due = cyc + 1;
`ifdef STOCH_STREAM_TAP_EN
                        check($sformatf("w%0d_tap_vld_count", W), vld_n, MAXV, 0);
                        check($sformatf("w%0d_tap_ones", W), ones_n, it.exp, it.tol);
                        vld_n  = 0;
                        ones_n = 0;
`endif
                    end
                end
            end
        end

`ifdef STOCH_STREAM_TAP_EN
        always @(posedge clk) begin
            ena_q <= ena;
            rst_q <= rst_n;
        end
`endif

        initial begin
            int pv, a, b, e, t;
            rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00; op_a = '0; op_b = '0;
            repeat (3) @(negedge clk);
            check($sformatf("w%0d_reset_busy", W), int'(busy), 0, 0);
            check($sformatf("w%0d_reset_done", W), int'(done), 0, 0);
            check($sformatf("w%0d_reset_result", W), int'(result), 0, 0);
            rst_n = 1'b1;
            armed = 1'b1;

            pv = (W == 4) ? 9 : (W == 8) ? 173 : 3000;
            run_op(3, pv, 0, 0, 0);
            run_op(2, 200 & MAXV, 57 & MAXV, 0, 0);
            run_op(2, 57 & MAXV, 200 & MAXV, 0, 0);
            run_op(2, 99 & MAXV, 99 & MAXV, 0, 0);

            if (FULL) begin
                run_op(0, 0, MAXV, 0, 0);
                run_op(0, MAXV, MAXV, 0, 0);
                run_op(0, (MAXV + 1) / 2, (MAXV + 1) / 2, 0, 0);
                run_op(1, 200 & MAXV, 50 & MAXV, 0, 0);
                run_op(3, 3, 0, 0, 0);
                run_op(3, MAXV, 0, 0, 0);
                run_op(3, 0, MAXV, 0, 0);

                // Second start pulse during RUN must be ignored.
                run_op(3, 5, 0, 0, 1);
                // ena low for 20 cycles mid-run just delays done.
                run_op(2, $urandom_range(0, MAXV), $urandom_range(0, MAXV), 20, 0);

                for (int i = 0; i < 10; i++)
                    run_op($urandom_range(0, 3), $urandom_range(0, MAXV), $urandom_range(0, MAXV), 0, (i % 3) == 0);

                // Abort: reset mid-run (also with ena low) clears result and suppresses done.
                run_op(3, 6, 0, 0, 0);
                @(negedge clk);
                mode = 2'b11; op_a = W'(7); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (MAXV / 2) @(negedge clk);
                rst_n = 1'b0; ena = 1'b0;
                @(negedge clk);
                rst_n = 1'b1; ena = 1'b1;
                check($sformatf("w%0d_abort_busy", W), int'(busy), 0, 0);
                check($sformatf("w%0d_abort_result", W), int'(result), 0, 0);
                check($sformatf("w%0d_abort_done", W), int'(done), 0, 0);
                repeat (MAXV + 20) @(negedge clk);
                run_op(2, $urandom_range(0, MAXV), $urandom_range(0, MAXV), 0, 0);

                // start held high: back-to-back runs one IDLE cycle apart.
                a = $urandom_range(0, MAXV);
                b = $urandom_range(0, MAXV);
                e = model(2, a, b, t);
                @(negedge clk);
                mode = 2'b10; op_a = W'(a); op_b = W'(b); start = 1'b1;
                sb.push_back('{exp: e, tol: t, due: cyc + (1 << W)});
                sb.push_back('{exp: e, tol: t, due: cyc + (2 << W) + 1});
                repeat ((1 << W) + 8) @(negedge clk);
                start = 1'b0;
                wait_idle();
            end
            repeat (4) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(u[0].fin && u[1].fin && u[2].fin) && t < 90000) begin
            @(negedge clk);
            t++;
        end
        check("all_blocks_finished", int'(u[0].fin && u[1].fin && u[2].fin), 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
